// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types: instruction formats, opcode constants, request struct
// and the immediate-fit helper used by the optional range check.
package riscv_pkg;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } instr_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        instr_fmt_e  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } enc_req_t;

    typedef enum logic {
        StIdle,
        StWrite
    } wr_state_e;

    // True when imm is representable as a signed value of the given bit width.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
        logic [31:0] w_hi;
        w_hi = 32'($signed(imm) >>> (bits - 1));
        return (w_hi == '0) || (w_hi == '1);
    endfunction

endpackage

// File: rtl/instr_encode_core.sv
// Combinational RV32I field encoder: request fields -> machine word plus legality flags.
// Define ENC_IMM_CHECK_EN to reject immediates that do not fit their format.
module instr_encode_core
    import riscv_pkg::*;
(
    input  enc_req_t    i_req,
    output logic [31:0] o_word,
    output logic        o_illegal,
    output logic        o_range_err
);

    logic [31:0] w_imm;
    assign w_imm = i_req.imm;

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_req.fmt)
            FmtR: begin
                o_illegal = (i_req.opcode != OPC_OP);
                o_word    = {i_req.func7, i_req.rs2, i_req.rs1, i_req.func3, i_req.rd,
                             i_req.opcode};
            end
            FmtI: begin
                o_illegal = (i_req.opcode != OPC_OP_IMM) && (i_req.opcode != OPC_LOAD);
                o_word    = {w_imm[11:0], i_req.rs1, i_req.func3, i_req.rd, i_req.opcode};
            end
            FmtS: begin
                o_illegal = (i_req.opcode != OPC_STORE);
                o_word    = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.func3, w_imm[4:0],
                             i_req.opcode};
            end
            FmtB: begin
                o_illegal = (i_req.opcode != OPC_BRANCH);
                o_word    = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.func3,
                             w_imm[4:1], w_imm[11], i_req.opcode};
            end
            FmtU: begin
                o_illegal = (i_req.opcode != OPC_LUI) && (i_req.opcode != OPC_AUIPC);
                o_word    = {w_imm[31:12], i_req.rd, i_req.opcode};
            end
            FmtJ: begin
                o_illegal = (i_req.opcode != OPC_JAL);
                o_word    = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd,
                             i_req.opcode};
            end
            default: o_illegal = 1'b1;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    logic w_range_bad;

    always_comb begin
        w_range_bad = 1'b0;
        case (i_req.fmt)
            FmtI, FmtS: w_range_bad = !imm_fits(w_imm, 12);
            FmtB:       w_range_bad = !imm_fits(w_imm, 13) || w_imm[0];
            FmtJ:       w_range_bad = !imm_fits(w_imm, 21) || w_imm[0];
            FmtU:       w_range_bad = (w_imm[11:0] != 12'd0);
            default:    w_range_bad = 1'b0;
        endcase
    end

    // An illegal pair is reported as illegal only, never also as a range fault.
    assign o_range_err = w_range_bad && !o_illegal;
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encode_writer.sv
// Encodes RV32I requests into a small FIFO and drains it into imem via a write/ack FSM.
// ENC_IMM_CHECK_EN enables immediate range rejection and the sticky err_range flag.
module instr_encode_writer
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_req_fmt,
    input  logic [6:0]        i_req_opcode,
    input  logic [4:0]        i_req_rd,
    input  logic [4:0]        i_req_rs1,
    input  logic [4:0]        i_req_rs2,
    input  logic [2:0]        i_req_func3,
    input  logic [6:0]        i_req_func7,
    input  logic [31:0]       i_req_imm,
    input  logic              i_flush,
    input  logic              i_err_clr,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    input  logic              i_imem_ack,
    output logic [ADDR_W:0]   o_wr_count,
    output logic              o_err_illegal,
    output logic              o_err_range,
    output logic              o_busy
);

    localparam int unsigned       PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    enc_req_t    w_req;
    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_range;

    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_cnt;
    logic [PtrW:0]     w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_wr_count;
    logic              r_err_illegal;
    wr_state_e         r_state;
    wr_state_e         w_state_nxt;

    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_req = '{fmt: instr_fmt_e'(i_req_fmt), opcode: i_req_opcode, rd: i_req_rd,
                     rs1: i_req_rs1, rs2: i_req_rs2, func3: i_req_func3,
                     func7: i_req_func7, imm: i_req_imm};

    instr_encode_core u_core (
        .i_req       (w_req),
        .o_word      (w_word),
        .o_illegal   (w_illegal),
        .o_range_err (w_range)
    );

    assign w_full      = (r_cnt == (PtrW+1)'(FIFO_DEPTH));
    assign o_req_ready = !w_full && !i_flush;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_push      = w_accept && !w_illegal && !w_range;
    assign w_pop       = (r_state == StWrite) && i_imem_ack;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_flush) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_cnt_nxt != '0) w_state_nxt = StWrite;
            StWrite: if (w_cnt_nxt == '0) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Address and head only move on pop, so outputs stay stable while waiting for ack.
    assign o_imem_we    = (r_state == StWrite);
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = o_imem_we ? r_mem[r_rd_ptr] : '0;
    assign o_wr_count   = r_wr_count;
    assign o_busy       = (r_cnt != '0) || o_imem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr     <= BaseAddr;
            r_wr_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_addr     <= BaseAddr;
                r_wr_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_word;
                    r_wr_ptr        <= r_wr_ptr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PtrW'(1);
                    r_addr   <= r_addr + ADDR_W'(1);
                    if (r_wr_count != '1) r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_illegal <= 1'b0;
        end else if (!i_flush) begin
            if (w_accept && w_illegal) r_err_illegal <= 1'b1;
            else if (i_err_clr)        r_err_illegal <= 1'b0;
        end
    end

    assign o_err_illegal = r_err_illegal;

`ifdef ENC_IMM_CHECK_EN
    logic r_err_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_range <= 1'b0;
        end else if (!i_flush) begin
            if (w_accept && w_range) r_err_range <= 1'b1;
            else if (i_err_clr)      r_err_range <= 1'b0;
        end
    end

    assign o_err_range = r_err_range;
`else
    assign o_err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encode_writer.sv
// Self-checking bench for instr_encode_writer: directed cases plus random traffic
// checked against an arithmetic encoder model and an expected-write queue.
module tb_instr_encode_writer;
    import riscv_pkg::*;

    localparam int unsigned AW     = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int          CNTMAX = (1 << (AW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_fmt = '0;
    logic [6:0]    req_opcode = '0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [2:0]    req_func3 = '0;
    logic [6:0]    req_func7 = '0;
    logic [31:0]   req_imm = '0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ack = 1'b0;
    logic [AW:0]   wr_count;
    logic          err_illegal;
    logic          err_range;
    logic          busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          exp_addr = 0;
    int          exp_cnt = 0;
    bit          exp_ill = 1'b0;
    bit          exp_rng = 1'b0;
    int          ack_mode = 0;
    logic [31:0] last_wdata = '0;
    int          last_addr = -1;
    bit          hold = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] hold_data = '0;

    instr_encode_writer #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_fmt     (req_fmt),
        .i_req_opcode  (req_opcode),
        .i_req_rd      (req_rd),
        .i_req_rs1     (req_rs1),
        .i_req_rs2     (req_rs2),
        .i_req_func3   (req_func3),
        .i_req_func7   (req_func7),
        .i_req_imm     (req_imm),
        .i_flush       (flush),
        .i_err_clr     (err_clr),
        .o_imem_we     (imem_we),
        .o_imem_addr   (imem_addr),
        .o_imem_wdata  (imem_wdata),
        .i_imem_ack    (imem_ack),
        .o_wr_count    (wr_count),
        .o_err_illegal (err_illegal),
        .o_err_range   (err_range),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [31:0] ref_enc(input int fmt, input logic [6:0] op,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] base;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            0: return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            1: return ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
            2: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base
                      | ((imm & 32'h1F) << 7);
            3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 32'h1) << 7);
            4: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'(op);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input int fmt, input logic [6:0] op);
        case (fmt)
            0: return op == 7'h33;
            1: return (op == 7'h13) || (op == 7'h03);
            2: return op == 7'h23;
            3: return op == 7'h63;
            4: return (op == 7'h37) || (op == 7'h17);
            5: return op == 7'h6F;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_range_ok(input int fmt, input logic [31:0] imm);
        int s;
        s = int'($signed(imm));
        case (fmt)
            1, 2: return (s >= -2048) && (s <= 2047);
            3: return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            5: return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
            4: return (imm & 32'hFFF) == 0;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        case (ack_mode)
            0: imem_ack = 1'b0;
            1: imem_ack = 1'b1;
            default: imem_ack = 1'($urandom_range(0, 1));
        endcase
    end

    // Write monitor: checks each acked word/address and that outputs hold while un-acked.
    always @(negedge clk) begin
        if (!rst_n || !imem_we) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_addr", 32'(imem_addr), hold_addr);
                chk("hold_wdata", imem_wdata, hold_data);
            end
            if (imem_ack) begin
                if (exp_q.size() == 0) chk("unexpected_write", imem_wdata, 32'hDEADBEEF);
                else chk("wdata", imem_wdata, exp_q.pop_front());
                chk("addr", 32'(imem_addr), 32'(exp_addr));
                last_addr  = int'(imem_addr);
                last_wdata = imem_wdata;
                exp_addr   = (exp_addr + 1) % (1 << AW);
                if (exp_cnt < CNTMAX) exp_cnt++;
                hold = 1'b0;
            end else begin
                hold      = 1'b1;
                hold_addr = 32'(imem_addr);
                hold_data = imem_wdata;
            end
        end
    end

    task automatic send(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n = 0;
        @(negedge clk);
        req_fmt = 3'(fmt); req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_func3 = f3; req_func7 = f7; req_imm = imm; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("send_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (!ref_legal(fmt, op)) exp_ill = 1'b1;
`ifdef ENC_IMM_CHECK_EN
        else if (!ref_range_ok(fmt, imm)) exp_rng = 1'b1;
`endif
        else exp_q.push_back(ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ack_mode = 1;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 200);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        exp_ill = 1'b0;
        exp_rng = 1'b0;
    endtask

    task automatic rand_send();
        int          fmt;
        logic [6:0]  op;
        logic [31:0] imm;
        fmt = $urandom_range(0, 6);
        case (fmt)
            0: op = 7'h33;
            1: op = ($urandom_range(0, 1) != 0) ? 7'h13 : 7'h03;
            2: op = 7'h23;
            3: op = 7'h63;
            4: op = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
            5: op = 7'h6F;
            default: op = 7'(($urandom));
        endcase
        if ($urandom_range(0, 7) == 0) op = 7'($urandom);
        if ($urandom_range(0, 1) != 0) imm = $urandom;
        else imm = 32'($urandom_range(0, 4095)) - 32'd2048 & ~32'h1;
        send(fmt, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             7'($urandom), imm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        chk("rst_err_range", 32'(err_range), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5 with ack held low: write appears the cycle after acceptance
        ack_mode = 0;
        send(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        chk("lat_we", 32'(imem_we), 32'd1);
        chk("lat_addr", 32'(imem_addr), 32'd0);
        chk("lat_wdata", imem_wdata, 32'h00500093);
        drain();
        chk("addi_wr_count", 32'(wr_count), 32'd1);

        send(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        drain();
        chk("add_word", last_wdata, 32'h002081B3);
        send(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8);
        drain();
        chk("beq_word", last_wdata, 32'hFE208CE3);
        send(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        drain();
        chk("jal_word", last_wdata, 32'h001000EF);
        send(4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        drain();
        chk("lui_word", last_wdata, 32'h123452B7);
        chk("lui_addr", 32'(last_addr), 32'd4);

        // Illegal pair is consumed without a write
        send(0, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        chk("ill_flag", 32'(err_illegal), 32'd1);
        chk("ill_no_we", 32'(imem_we), 32'd0);
        chk("ill_ready", 32'(req_ready), 32'd1);
        chk("ill_wr_count", 32'(wr_count), 32'(exp_cnt));
        clear_errors();
        @(negedge clk);
        chk("ill_cleared", 32'(err_illegal), 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        send(6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_vs_new_err", 32'(err_illegal), 32'(exp_ill));

        // Flush with ack low and three words queued; errors survive, err_clr ignored
        ack_mode = 0;
        for (int i = 0; i < 3; i++) send(1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        @(negedge clk);
        chk("pre_flush_we", 32'(imem_we), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        err_clr = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        err_clr = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        exp_cnt = 0;
        @(negedge clk);
        chk("flush_we", 32'(imem_we), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_addr", 32'(imem_addr), 32'd0);
        chk("flush_wr_count", 32'(wr_count), 32'd0);
        chk("flush_keeps_err", 32'(err_illegal), 32'd1);
        clear_errors();

        // Backpressure: four fill the FIFO, fifth is refused until ack resumes
        ack_mode = 0;
        for (int i = 0; i < 4; i++) send(1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        @(negedge clk);
        req_fmt = 3'd1; req_opcode = 7'h13; req_valid = 1'b1;
        #1;
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        req_valid = 1'b0;
        ack_mode = 1;
        send(1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        send(1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        drain();
        chk("bp_last_addr", 32'(last_addr), 32'd5);
        chk("bp_wr_count", 32'(wr_count), 32'd6);

        // Pointer wrap: writes land at 6, 7, then 0
        for (int i = 0; i < 3; i++) send(2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'(i * 4));
        drain();
        chk("wrap_addr", 32'(last_addr), 32'd0);
        chk("wrap_wr_count", 32'(wr_count), 32'd9);

        // Out-of-range immediate for I format
        send(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        drain();
        chk("imm_err_range", 32'(err_range), 32'(exp_rng));
        chk("imm_wr_count", 32'(wr_count), 32'(exp_cnt));
`ifndef ENC_IMM_CHECK_EN
        chk("imm_trunc_word", last_wdata, 32'h00000093);
`endif

        // Random traffic with random ack; wr_count saturates
        ack_mode = 2;
        for (int i = 0; i < 60; i++) rand_send();
        drain();
        chk("rnd_wr_count", 32'(wr_count), 32'(exp_cnt));
        chk("rnd_err_illegal", 32'(err_illegal), 32'(exp_ill));
        chk("rnd_err_range", 32'(err_range), 32'(exp_rng));

        // Asynchronous reset while a write is pending
        ack_mode = 0;
        send(1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        @(negedge clk);
        chk("prerst_we", 32'(imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr_count", 32'(wr_count), 32'd0);
        chk("arst_err", 32'(err_illegal), 32'd0);
        exp_q.delete();
        exp_addr = 0;
        exp_cnt = 0;
        exp_ill = 1'b0;
        exp_rng = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        send(1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        drain();
        chk("postrst_addr", 32'(last_addr), 32'd0);
        chk("postrst_wr_count", 32'(wr_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
